exe_mem_skid_stage: RTL

//  Parametrised EX->MEM pipeline boundary: registers the EX payload/control bundle with valid/ready flow control.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_skid_entry.sv | 41 ++++
 rtl/exe_mem_skid_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM skid stage: control-bundle layout and stage occupancy states.
package pipe_pkg;

  localparam int CTRL_W     = 5;
  localparam int CTRL_MEMRD = 4;
  localparam int CTRL_MEMWR = 3;
  localparam int CTRL_IN    = 2;
  localparam int CTRL_OUT   = 1;
  localparam int CTRL_REGWR = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline slot: valid bit, data payload held across clears, control payload zeroed on clear.
module pipe_skid_entry #(
  parameter int DW = 16,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] d_data,
  input  logic [CW-1:0] d_ctrl,
  output logic          valid,
  output logic [DW-1:0] q_data,
  output logic [CW-1:0] q_ctrl
);

  logic          valid_r;
  logic [DW-1:0] data_r;
  logic [CW-1:0] ctrl_r;

  // Slot register; an empty slot never carries live control bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      ctrl_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= d_data;
      ctrl_r  <= d_ctrl;
    end else if (clear) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
    end
  end

  assign valid  = valid_r;
  assign q_data = data_r;
  assign q_ctrl = ctrl_r;

endmodule

// File: rtl/exe_mem_skid_stage.sv
// EX->MEM boundary with a two-slot skid so in_ready comes straight from a flop.
// Optional MEM_STAGE_STALL_CNT_EN adds a saturating backpressure-cycle counter on stall_cnt.
module exe_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int N     = 16,
  parameter int RA_W  = 3,
  parameter int MTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_pc,
  input  logic [N-1:0]      in_inst,
  input  logic [N-1:0]      in_alu,
  input  logic [N-1:0]      in_rd1,
  input  logic [N-1:0]      in_rd2,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [MTR_W-1:0]  in_mtr,
  input  logic [RA_W-1:0]   in_wreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_pc,
  output logic [N-1:0]      out_inst,
  output logic [N-1:0]      out_alu,
  output logic [N-1:0]      out_rd1,
  output logic [N-1:0]      out_rd2,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [MTR_W-1:0]  out_mtr,
  output logic [RA_W-1:0]   out_wreg
`ifdef MEM_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int DW = 5 * N + RA_W;
  localparam int CW = CTRL_W + MTR_W;

  logic [DW-1:0] in_data_s, m_data_s, s_data_s, m_d_data_s;
  logic [CW-1:0] in_cw_s, m_cw_s, s_cw_s, m_d_cw_s;
  logic          m_valid_s, s_valid_s;
  logic          accept_s, drain_s;
  logic          m_load_s, m_clear_s, m_from_s_s, s_load_s, s_clear_s;
  logic          in_ready_r;
  stage_state_e  state_r, state_nxt_s;

  assign in_data_s  = {in_pc, in_inst, in_alu, in_rd1, in_rd2, in_wreg};
  assign in_cw_s    = {in_ctrl, in_mtr};
  assign accept_s   = in_valid & in_ready_r;
  assign drain_s    = m_valid_s & out_ready;
  assign m_d_data_s = m_from_s_s ? s_data_s : in_data_s;
  assign m_d_cw_s   = m_from_s_s ? s_cw_s : in_cw_s;

  // Occupancy state and the registered ready it implies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != TWO);
    end
  end

  // Next occupancy and slot load/clear strobes; flush drops inputs but lets a drain complete.
  always_comb begin
    state_nxt_s = state_r;
    m_load_s    = 1'b0;
    m_clear_s   = 1'b0;
    m_from_s_s  = 1'b0;
    s_load_s    = 1'b0;
    s_clear_s   = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
      m_clear_s   = 1'b1;
      s_clear_s   = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            m_load_s    = 1'b1;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && drain_s) begin
            m_load_s = 1'b1;
          end else if (accept_s) begin
            s_load_s    = 1'b1;
            state_nxt_s = TWO;
          end else if (drain_s) begin
            m_clear_s   = 1'b1;
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        TWO: begin
          if (drain_s && s_valid_s) begin
            m_load_s    = 1'b1;
            m_from_s_s  = 1'b1;
            s_clear_s   = 1'b1;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = TWO;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          m_clear_s   = 1'b1;
          s_clear_s   = 1'b1;
        end
      endcase
    end
  end

  pipe_skid_entry #(.DW(DW), .CW(CW)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (m_load_s),
    .clear  (m_clear_s),
    .d_data (m_d_data_s),
    .d_ctrl (m_d_cw_s),
    .valid  (m_valid_s),
    .q_data (m_data_s),
    .q_ctrl (m_cw_s)
  );

  pipe_skid_entry #(.DW(DW), .CW(CW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (s_load_s),
    .clear  (s_clear_s),
    .d_data (in_data_s),
    .d_ctrl (in_cw_s),
    .valid  (s_valid_s),
    .q_data (s_data_s),
    .q_ctrl (s_cw_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = m_valid_s;
  assign {out_pc, out_inst, out_alu, out_rd1, out_rd2, out_wreg} = m_data_s;
  assign {out_ctrl, out_mtr} = m_cw_s;

`ifdef MEM_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles the MEM stage holds back a valid bundle; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (m_valid_s && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule
